// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//
// Multi-lane instruction queue sitting between fetch and decode. Each cycle
// fetch may present up to WR_LANES {inst, pc} pairs under a sparse lane mask.
// The set lanes are squeezed together and appended in program order to a
// circular buffer. Decode sees the oldest RD_LANES entries combinationally.
// It consumes rd_cnt of them per cycle.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst         asynchronous active-low reset (pointers, count, err)
//   clr         synchronous flush, active-high, beats everything but rst
//   inst_i      WR_LANES packed instructions, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pc_i        WR_LANES packed pcs, packed the same way
//   inst_wen    per-lane write valid, any pattern legal
//   in_ready    queue has room for a full write group this cycle
//   rd_cnt      number of oldest entries decode consumes this cycle
//   inst_o      RD_LANES packed instructions, lane j = entry r_ptr+j
//   pc_o        RD_LANES packed pcs, lane j = entry r_ptr+j
//   out_valid   bit j set when more than j entries are held
//   inst_count  occupancy, 0..DEPTH inclusive
//   full        inst_count == DEPTH
//   err         sticky flag, set when decode asks for more than is held
// ---------------------------------------------------------------------------
module inst_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int WR_LANES   = 8,
  parameter int RD_LANES   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic [WR_LANES*DATA_WIDTH-1:0]   inst_i,
  input  logic [WR_LANES*ADDR_WIDTH-1:0]   pc_i,
  input  logic [WR_LANES-1:0]              inst_wen,
  output logic                             in_ready,
  input  logic [$clog2(RD_LANES+1)-1:0]    rd_cnt,
  output logic [RD_LANES*DATA_WIDTH-1:0]   inst_o,
  output logic [RD_LANES*ADDR_WIDTH-1:0]   pc_o,
  output logic [RD_LANES-1:0]              out_valid,
  output logic [$clog2(DEPTH+1)-1:0]       inst_count,
  output logic                             full,
  output logic                             err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // One spare bit so add-then-subtract on the count can never wrap midway.
  localparam int EW = CW + 1;

  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic [PW-1:0] wr_idx [WR_LANES];
  logic [PW-1:0] rd_idx [RD_LANES];
  logic [EW-1:0] n_wr;
  logic [EW-1:0] cnt_ext;
  logic [EW-1:0] rd_ext;
  logic [EW-1:0] rd_eff;
  logic [CW-1:0] cnt_next;
  logic          acc;
  logic          over_rd;

  // Compaction: each set lane lands at w_ptr plus the number of set lanes
  // below it, so holes in the mask vanish and program order is kept.
  always_comb begin
    n_wr = '0;
    for (int i = 0; i < WR_LANES; i++) begin
      wr_idx[i] = w_ptr + PW'(n_wr);
      n_wr      = n_wr + EW'(inst_wen[i]);
    end
  end

  // Readiness only looks at registered occupancy, so it never depends on
  // what decode drains in the same cycle.
  always_comb begin
    cnt_ext  = EW'(inst_count);
    rd_ext   = EW'(rd_cnt);
    in_ready = (EW'(DEPTH) - cnt_ext) >= EW'(WR_LANES);
    acc      = (|inst_wen) & in_ready & ~clr;
    over_rd  = rd_ext > cnt_ext;
    rd_eff   = over_rd ? cnt_ext : rd_ext;
    cnt_next = CW'(cnt_ext + (acc ? n_wr : '0) - rd_eff);
    full     = (inst_count == CW'(DEPTH));
  end

  // Read window: oldest entries straight from storage, wrapping modulo DEPTH.
  always_comb begin
    for (int j = 0; j < RD_LANES; j++) begin
      rd_idx[j] = r_ptr + PW'(j);
      inst_o[j*DATA_WIDTH +: DATA_WIDTH] = inst_mem[rd_idx[j]];
      pc_o[j*ADDR_WIDTH +: ADDR_WIDTH]   = pc_mem[rd_idx[j]];
      out_valid[j] = cnt_ext > EW'(j);
    end
  end

  // Pointer/count/error state. A flush discards any write or read offered
  // in the same cycle. An over-read is clamped to what is held and latched in err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      inst_count <= '0;
      err        <= 1'b0;
    end else if (clr) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      inst_count <= '0;
      err        <= 1'b0;
    end else begin
      if (acc) w_ptr <= w_ptr + PW'(n_wr);
      r_ptr      <= r_ptr + PW'(rd_eff);
      inst_count <= cnt_next;
      if (over_rd) err <= 1'b1;
    end
  end

  // Storage is deliberately not reset; out_valid qualifies the read data.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int i = 0; i < WR_LANES; i++) begin
        if (inst_wen[i]) begin
          inst_mem[wr_idx[i]] <= inst_i[i*DATA_WIDTH +: DATA_WIDTH];
          pc_mem[wr_idx[i]]   <= pc_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised multi-lane instruction queue between fetch and decode; next generation of the fetch-side instruction buffer.
- Accepts up to WR_LANES {inst, pc} pairs per cycle from a sparse lane mask and stores them compacted in program order.
- Presents the oldest RD_LANES entries with per-lane valid bits to decode.
- Adds full/ready backpressure, a full-depth occupancy count, clamped reads and a sticky over-read error flag.

Parameters:
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, pc width
- DEPTH, 32, entry count; power of two, >= 2*WR_LANES
- WR_LANES, 8, write lanes per cycle
- RD_LANES, 4, read lanes per cycle; <= DEPTH

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush (redirect/mispredict), active-high
- inst_i  in  WR_LANES*DATA_WIDTH  lane i instruction at bits [i*DATA_WIDTH +: DATA_WIDTH]
- pc_i  in  WR_LANES*ADDR_WIDTH  lane i pc, packed the same way
- inst_wen  in  WR_LANES  per-lane write valid; any bit pattern is legal
- in_ready  out  1  queue can take a full write group this cycle
- rd_cnt  in  $clog2(RD_LANES+1)  number of oldest entries decode consumes this cycle
- inst_o  out  RD_LANES*DATA_WIDTH  lane j = entry r_ptr+j
- pc_o  out  RD_LANES*ADDR_WIDTH  lane j = pc of entry r_ptr+j
- out_valid  out  RD_LANES  bit j = (inst_count > j)
- inst_count  out  $clog2(DEPTH+1)  occupancy, 0..DEPTH inclusive
- full  out  1  inst_count == DEPTH
- err  out  1  sticky over-read flag

Behaviour:
- Reset (rst=0, asynchronous):
  - w_ptr, r_ptr, inst_count and err all go to 0.
  - Resulting outputs: out_valid=0, full=0, in_ready=1.
  - Storage is not reset. inst_o/pc_o are don't-care wherever out_valid=0.
- in_ready is combinational from registered state only: (DEPTH - inst_count) >= WR_LANES. It does not depend on rd_cnt in the same cycle (conservative).
- Write accept: acc = (|inst_wen) & in_ready & ~clr.
  - If acc, let n = popcount(inst_wen). The k-th set bit (from lane 0 upward) is written to entry (w_ptr+k) mod DEPTH. Holes in the mask are squeezed out.
  - No other entry is modified. w_ptr += n.
  - If in_ready=0, the write is dropped and nothing changes. Fetch must hold and retry.
- Read:
  - rd_eff = min(rd_cnt, inst_count), using the pre-update count. r_ptr += rd_eff, modulo DEPTH.
  - If rd_cnt > inst_count, err is set to 1 and stays 1 until reset or clr. The read is clamped to rd_eff.
- Count update: inst_count_next = inst_count + (acc ? n : 0) - rd_eff. The arithmetic is done at width $clog2(DEPTH+1)+1 so there is no intermediate wrap.
- Simultaneous write and read:
  - Both are applied in the same cycle.
  - There is no write-to-read bypass. Newly written entries become visible in out_valid/inst_o on the next cycle.
  - A read in the same cycle never sees data written in that cycle.
- Pointer wrap: all pointer and index arithmetic is modulo DEPTH. Write groups and read windows that straddle entry DEPTH-1 wrap to entry 0 seamlessly.
- Flush (clr=1):
  - Next cycle, w_ptr = r_ptr = inst_count = 0 and err = 0.
  - Any write or read presented in the flush cycle is discarded.
  - clr takes priority over everything except rst.
- Outputs: inst_o/pc_o lane j is read combinationally from entry (r_ptr+j) mod DEPTH. Read latency is 0 cycles from state; write-to-visible latency is 1 cycle.
- Boundaries:
  - Empty: out_valid=0, and rd_cnt>0 sets err.
  - Full: in_ready=0; reads still proceed.
  - inst_count never exceeds DEPTH.
  - inst_wen=0 with in_ready=1 is a no-op write.

Test Plan:
- Reset then sparse write: inst_wen=8'b1010_0101, lanes 0,2,5,7 carrying pc 0x100/0x108/0x114/0x11C -> next cycle inst_count=4, out_valid=4'b1111, pc_o lanes 0..3 = 0x100, 0x108, 0x114, 0x11C.
- Fill to backpressure (DEPTH=32): three full 8-lane writes -> inst_count=24, in_ready=1. A fourth write -> inst_count=32, full=1, in_ready=0. A fifth write is dropped and inst_count stays 32.
- Wrap-around: pre-position pointers at 28 with 0 entries, then write 8 lanes -> entries 28..31 and 0..3 hold the group in order. Read rd_cnt=4 twice -> pc sequence is continuous and inst_count=0.
- Simultaneous events:
  - With inst_count=3, write 8 lanes and set rd_cnt=4 -> err=1, rd_eff=3, next inst_count=8, and out_valid in the same cycle still shows only 3 lanes.
  - err stays 1 across later legal cycles.
- Flush priority: with inst_count=12, assert clr together with an 8-lane write and rd_cnt=2 -> next cycle inst_count=0, out_valid=0, err=0, in_ready=1.
- Async reset mid-operation: drop rst between clock edges while inst_count=17 -> outputs go immediately to inst_count=0, out_valid=0, full=0 without waiting for a clk edge. After rst releases, the first write lands at entry 0.
